// File: rtl/calc_input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// calc_input_conditioner_pkg : shared defaults for the calc input front end
// Rev 1.0
// ============================================================================
package calc_input_conditioner_pkg;

  localparam int C_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
  localparam int C_CNT_W           = 20;
  localparam int C_SW_W            = 16;
  localparam int C_NUM_BTN         = 4;
  localparam int C_BTN_ENTER       = 0;       // btnd sits at bit 0 of the button vector

endpackage
`default_nettype wire

// File: rtl/calc_input_conditioner_debounce.sv
`default_nettype none
// ============================================================================
// calc_debounce : 2-flop synchroniser, hold-time debouncer and rise strobe
// Rev 1.0
// ============================================================================
module calc_debounce
  import calc_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
  parameter int CNT_W           = C_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic rise,
  output logic rise_next
);

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic             rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only advances while the synchronised input disagrees with the
  // stable level; it clears at the terminal count, so it never wraps.
  always_comb begin
    sync1_d  = raw_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    rise_d   = 1'b0;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == TERM_CNT) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      cnt_q    <= cnt_d;
    end
  end

  assign level     = stable_q;
  assign rise      = rise_q;
  assign rise_next = rise_d;

endmodule
`default_nettype wire

// File: rtl/calc_input_conditioner.sv
`default_nettype none
// ============================================================================
// calc_input_conditioner : debounced buttons, enter strobe, op/operand capture
// Rev 1.0
// ============================================================================
module calc_input_conditioner
  import calc_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = C_DEBOUNCE_CYCLES,
  parameter int CNT_W           = C_CNT_W,
  parameter int SW_W            = C_SW_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            btnl_raw,
  input  logic            btnc_raw,
  input  logic            btnr_raw,
  input  logic            btnd_raw,
  input  logic [SW_W-1:0] sw_raw,
  output logic            enter_pulse,
  output logic [2:0]      op_q,
  output logic [SW_W-1:0] sw_q,
  output logic [3:0]      btn_level
);

  logic [C_NUM_BTN-1:0] btn_raw_w;
  logic [C_NUM_BTN-1:0] level_w;
  logic [C_NUM_BTN-1:0] rise_w;
  logic [C_NUM_BTN-1:0] rise_next_w;
  logic                 unused_rise;

  logic [SW_W-1:0] sw_sync1_q, sw_sync1_d;
  logic [SW_W-1:0] sw_sync2_q, sw_sync2_d;
  logic [SW_W-1:0] sw_d;
  logic [2:0]      op_d;

  assign btn_raw_w = {btnl_raw, btnc_raw, btnr_raw, btnd_raw};

  generate
    for (genvar i = 0; i < C_NUM_BTN; i++) begin : g_btn
      calc_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
      ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .raw_in    (btn_raw_w[i]),
        .level     (level_w[i]),
        .rise      (rise_w[i]),
        .rise_next (rise_next_w[i])
      );
    end
  endgenerate

  // Only btnd drives a strobe; op buttons are consumed as levels.
  assign unused_rise = ^{rise_w[C_NUM_BTN-1:1], rise_next_w[C_NUM_BTN-1:1]};

  // Capture fires on the edge the enter strobe is set, so it sees the op
  // levels and synchronised switches as they were before that edge.
  always_comb begin
    sw_sync1_d = sw_raw;
    sw_sync2_d = sw_sync1_q;
    op_d       = op_q;
    sw_d       = sw_q;
    if (rise_next_w[C_BTN_ENTER]) begin
      op_d = level_w[3:1];
      sw_d = sw_sync2_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      op_q       <= '0;
      sw_q       <= '0;
    end else begin
      sw_sync1_q <= sw_sync1_d;
      sw_sync2_q <= sw_sync2_d;
      op_q       <= op_d;
      sw_q       <= sw_d;
    end
  end

  assign enter_pulse = rise_w[C_BTN_ENTER];
  assign btn_level   = level_w;

endmodule
`default_nettype wire

// File: tb/tb_calc_input_conditioner.sv
`default_nettype none
// ============================================================================
// tb_calc_input_conditioner : scoreboard bench, directed press/bounce vectors
// Rev 1.0
// ============================================================================
module tb_calc_input_conditioner;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        btnl_raw, btnc_raw, btnr_raw, btnd_raw;
  logic [15:0] sw_raw;
  logic        enter_pulse;
  logic [2:0]  op_q;
  logic [15:0] sw_q;
  logic [3:0]  btn_level;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  op;
    logic [15:0] sw;
  } exp_t;

  exp_t exp_q[$];

  calc_input_conditioner #(
    .DEBOUNCE_CYCLES (DEB),
    .CNT_W           (3),
    .SW_W            (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btnl_raw    (btnl_raw),
    .btnc_raw    (btnc_raw),
    .btnr_raw    (btnr_raw),
    .btnd_raw    (btnd_raw),
    .sw_raw      (sw_raw),
    .enter_pulse (enter_pulse),
    .op_q        (op_q),
    .sw_q        (sw_q),
    .btn_level   (btn_level)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_press(input logic [2:0] op, input logic [15:0] sw, input int lat);
    exp_t e;
    e.cyc = cyc + lat;
    e.op  = op;
    e.sw  = sw;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse"}, {31'd0, enter_pulse}, 32'd0);
    check({tag, "_op"},    {29'd0, op_q},        32'd0);
    check({tag, "_sw"},    {16'd0, sw_q},        32'd0);
    check({tag, "_level"}, {28'd0, btn_level},   32'd0);
  endtask

  // Monitor: every observed strobe must match the next queued press.
  always @(negedge clk) begin
    if (enter_pulse === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", cyc,              e.cyc);
        check("capt_op",     {29'd0, op_q},    {29'd0, e.op});
        check("capt_sw",     {16'd0, sw_q},    {16'd0, e.sw});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst      = 1'b1;
    btnl_raw = 1'b1;
    btnc_raw = 1'b1;
    btnr_raw = 1'b1;
    btnd_raw = 1'b1;
    sw_raw   = 16'hffff;

    // Reset with every raw input high, then one cycle after release.
    tick(1);
    check_zero("rst_a");
    tick(1);
    check_zero("rst_b");
    rst = 1'b0;
    tick(1);
    check_zero("rst_c");
    btnl_raw = 1'b0;
    btnc_raw = 1'b0;
    btnr_raw = 1'b0;
    btnd_raw = 1'b0;
    sw_raw   = 16'h0000;
    tick(10);
    check("post_rst_level", {28'd0, btn_level}, 32'd0);

    // Clean press with centre op.
    btnc_raw = 1'b1;
    sw_raw   = 16'h354a;
    tick(8);
    btnd_raw = 1'b1;
    expect_press(3'b010, 16'h354a, 2 + DEB);
    tick(20);
    check("clean_op_hold",  {29'd0, op_q},      32'h2);
    check("clean_sw_hold",  {16'd0, sw_q},      32'h354a);
    check("clean_level",    {28'd0, btn_level}, 32'h5);

    // Release, then bounce with 3-cycle high/low phases: never a full window.
    btnd_raw = 1'b0;
    tick(10);
    for (int i = 0; i < 5; i++) begin
      btnd_raw = 1'b1;
      tick(3);
      check("bounce_level_hi", {31'd0, btn_level[0]}, 32'd0);
      btnd_raw = 1'b0;
      tick(3);
      check("bounce_level_lo", {31'd0, btn_level[0]}, 32'd0);
    end
    tick(10);
    check("bounce_level_end", {31'd0, btn_level[0]}, 32'd0);

    // Second operation with left+right, then a later switch change.
    btnc_raw = 1'b0;
    btnl_raw = 1'b1;
    btnr_raw = 1'b1;
    sw_raw   = 16'h0004;
    tick(8);
    btnd_raw = 1'b1;
    expect_press(3'b101, 16'h0004, 2 + DEB);
    tick(10);
    sw_raw = 16'h1234;
    tick(10);
    check("second_op_hold", {29'd0, op_q}, 32'h5);
    check("second_sw_hold", {16'd0, sw_q}, 32'h0004);
    btnd_raw = 1'b0;
    tick(10);

    // Reset on the 4th edge of a press restarts the whole window.
    btnl_raw = 1'b0;
    btnr_raw = 1'b0;
    sw_raw   = 16'habcd;
    tick(8);
    btnd_raw = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    check("midrst_op", {29'd0, op_q}, 32'd0);
    check("midrst_sw", {16'd0, sw_q}, 32'd0);
    rst = 1'b0;
    expect_press(3'b000, 16'habcd, 2 + DEB);
    tick(12);
    btnd_raw = 1'b0;
    tick(10);

    // Switch and op change land on the same edge the enter level flips.
    sw_raw = 16'h1001;
    tick(8);
    btnd_raw = 1'b1;
    btnc_raw = 1'b1;
    expect_press(3'b000, 16'h1001, 2 + DEB);
    tick(4);
    sw_raw = 16'hf0f0;
    tick(10);
    check("coh_level", {28'd0, btn_level}, 32'h5);
    check("coh_sw",    {16'd0, sw_q},      32'h1001);

    tick(5);
    check("missing_pulses", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
